// File: rtl/ifmap_wadr_gen.sv
// ifmap_wadr_gen: write-side address generator and ping-pong bank controller
// for the input-activation double buffer. Words arrive in ix-fastest, then iy,
// then ic order; each accepted word gets a bank-local linear address. A bank
// that has received a complete tile is marked full and handed to the reader,
// which releases it when it has finished consuming it.
module ifmap_wadr_gen #(
  parameter int BANK_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         config_en,
  input  logic [3*BANK_ADDR_WIDTH-1:0] config_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         wen,
  output logic [BANK_ADDR_WIDTH-1:0]   wadr,
  output logic                         wbank,
  output logic                         tile_done,
  output logic                         rd_bank,
  output logic                         rd_bank_valid,
  input  logic                         rd_release,
  output logic                         cfg_err
);

  localparam int W  = BANK_ADDR_WIDTH;
  localparam int TW = 3 * BANK_ADDR_WIDTH;

  // Largest tile that fits in one bank: 2^W words.
  localparam logic [TW-1:0] TILE_LIMIT = {{(TW-W-1){1'b0}}, 1'b1, {W{1'b0}}};

  // Configuration registers
  logic [W-1:0] ix0_reg;
  logic [W-1:0] iy0_reg;
  logic [W-1:0] ic1_reg;
  logic         configured_reg;
  logic         cfg_err_reg;

  // Tile position counters and linear address
  logic [W-1:0] ix_reg;
  logic [W-1:0] iy_reg;
  logic [W-1:0] ic_reg;
  logic [W-1:0] lin_reg;

  // Ping-pong bookkeeping
  logic         wbank_reg;
  logic         rd_bank_reg;
  logic [1:0]   full_reg;
  logic [1:0]   full_next;
  logic         tile_done_reg;

  // Incoming configuration fields and tile-size validity check
  logic [W-1:0]  cfg_ix0;
  logic [W-1:0]  cfg_iy0;
  logic [W-1:0]  cfg_ic1;
  logic [TW-1:0] cfg_size;
  logic          cfg_bad;

  // Per-word control
  logic ix_last;
  logic iy_last;
  logic ic_last;
  logic tile_last;
  logic release_ok;

  assign cfg_ix0  = config_data[3*W-1:2*W];
  assign cfg_iy0  = config_data[2*W-1:W];
  assign cfg_ic1  = config_data[W-1:0];
  assign cfg_size = TW'(cfg_ix0) * TW'(cfg_iy0) * TW'(cfg_ic1);
  assign cfg_bad  = (cfg_ix0 == '0) || (cfg_iy0 == '0) || (cfg_ic1 == '0) ||
                    (cfg_size > TILE_LIMIT);

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = configured_reg & ~full_reg[wbank_reg];

  // A word offered in a config or reset cycle is dropped, so it must not
  // reach the buffer either.
  assign wen = in_valid & in_ready & ~config_en & ~rst;

  assign ix_last   = (ix_reg == ix0_reg - W'(1));
  assign iy_last   = (iy_reg == iy0_reg - W'(1));
  assign ic_last   = (ic_reg == ic1_reg - W'(1));
  assign tile_last = wen & ix_last & iy_last & ic_last;

  // A release of an empty bank is ignored.
  assign release_ok = rd_release & configured_reg & full_reg[rd_bank_reg];

  // Per-bank full flag: set by the last write of a tile, cleared by release.
  // Both may happen in one cycle; they always target different banks because
  // a write needs an empty bank and a release needs a full one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      assign full_next[gi] =
        (full_reg[gi] & ~(release_ok & (rd_bank_reg == 1'(gi)))) |
        (tile_last & (wbank_reg == 1'(gi)));
    end
  endgenerate

  // Configuration, address counters and bank bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ix0_reg        <= '0;
      iy0_reg        <= '0;
      ic1_reg        <= '0;
      configured_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
      ix_reg         <= '0;
      iy_reg         <= '0;
      ic_reg         <= '0;
      lin_reg        <= '0;
      wbank_reg      <= 1'b0;
      rd_bank_reg    <= 1'b0;
      full_reg       <= 2'b00;
      tile_done_reg  <= 1'b0;
    end else if (config_en) begin
      ix0_reg        <= cfg_ix0;
      iy0_reg        <= cfg_iy0;
      ic1_reg        <= cfg_ic1;
      configured_reg <= ~cfg_bad;
      cfg_err_reg    <= cfg_bad;
      ix_reg         <= '0;
      iy_reg         <= '0;
      ic_reg         <= '0;
      lin_reg        <= '0;
      wbank_reg      <= 1'b0;
      rd_bank_reg    <= 1'b0;
      full_reg       <= 2'b00;
      tile_done_reg  <= 1'b0;
    end else begin
      tile_done_reg <= tile_last;
      full_reg      <= full_next;
      if (release_ok) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
      if (tile_last) begin
        ix_reg    <= '0;
        iy_reg    <= '0;
        ic_reg    <= '0;
        lin_reg   <= '0;
        wbank_reg <= ~wbank_reg;
      end else if (wen) begin
        lin_reg <= lin_reg + W'(1);
        if (ix_last) begin
          ix_reg <= '0;
          if (iy_last) begin
            iy_reg <= '0;
            ic_reg <= ic_reg + W'(1);
          end else begin
            iy_reg <= iy_reg + W'(1);
          end
        end else begin
          ix_reg <= ix_reg + W'(1);
        end
      end
    end
  end

  assign wadr          = lin_reg;
  assign wbank         = wbank_reg;
  assign tile_done     = tile_done_reg;
  assign rd_bank       = rd_bank_reg;
  assign rd_bank_valid = full_reg[rd_bank_reg];
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_ifmap_wadr_gen.sv
// Testbench for ifmap_wadr_gen. Expected writes go into a scoreboard queue
// from the stimulus side; a monitor pops and compares on every wen.
// The reference model tracks a write index within the tile plus a count of
// completed-but-unreleased tiles.
module tb_ifmap_wadr_gen;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           config_en;
  logic [3*W-1:0] config_data;
  logic           in_valid;
  logic           in_ready;
  logic           wen;
  logic [W-1:0]   wadr;
  logic           wbank;
  logic           tile_done;
  logic           rd_bank;
  logic           rd_bank_valid;
  logic           rd_release;
  logic           cfg_err;

  ifmap_wadr_gen #(.BANK_ADDR_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .config_en    (config_en),
    .config_data  (config_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wen          (wen),
    .wadr         (wadr),
    .wbank        (wbank),
    .tile_done    (tile_done),
    .rd_bank      (rd_bank),
    .rd_bank_valid(rd_bank_valid),
    .rd_release   (rd_release),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int adr;
    int bank;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  bit m_ok  = 1'b0;   // configured with a valid tile
  bit m_err = 1'b0;
  bit m_td  = 1'b0;
  int m_t   = 0;      // tile size in words
  int m_n   = 0;      // words already written into the current tile
  int m_wb  = 0;      // bank being written
  int m_nf  = 0;      // completed tiles not yet released (0..2)

  function automatic int model_rd_bank();
    // Oldest unreleased tile sits in the bank opposite the writer when one
    // tile is pending; with zero or two pending it is the writer's bank.
    return (m_nf == 1) ? (m_wb ^ 1) : m_wb;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, advance model, compare status.
  task automatic cycle(input bit v, input bit r, input bit c,
                       input int cx, input int cy, input int cz, input bit rs);
    bit acc;
    bit relok;
    int t;
    rst         = rs;
    config_en   = c;
    config_data = {cx[W-1:0], cy[W-1:0], cz[W-1:0]};
    in_valid    = v;
    rd_release  = r;
    acc   = m_ok && (m_nf < 2) && v && !c && !rs;
    relok = m_ok && r && (m_nf > 0) && !c && !rs;
    if (acc) sb_q.push_back('{adr: m_n, bank: m_wb});
    @(posedge clk);
    #2;
    m_td = 1'b0;
    if (rs) begin
      m_ok = 0; m_err = 0; m_t = 0; m_n = 0; m_wb = 0; m_nf = 0;
    end else if (c) begin
      t     = cx * cy * cz;
      m_err = (cx == 0) || (cy == 0) || (cz == 0) || (t > (1 << W));
      m_ok  = !m_err;
      m_t   = t;
      m_n = 0; m_wb = 0; m_nf = 0;
    end else begin
      if (acc) begin
        m_n++;
        if (m_n == m_t) begin
          m_n  = 0;
          m_wb ^= 1;
          m_nf++;
          m_td = 1'b1;
        end
      end
      if (relok) m_nf--;
    end
    check("in_ready",      int'(in_ready),      int'(m_ok && (m_nf < 2)));
    check("rd_bank_valid", int'(rd_bank_valid), int'(m_nf > 0));
    check("rd_bank",       int'(rd_bank),       model_rd_bank());
    check("wbank",         int'(wbank),         m_wb);
    check("tile_done",     int'(tile_done),     int'(m_td));
    check("cfg_err",       int'(cfg_err),       int'(m_err));
  endtask

  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic cfg(input int cx, input int cy, input int cz, input bit v);
    cycle(v, 1'b0, 1'b1, cx, cy, cz, 1'b0);
    check("wadr_after_cfg", int'(wadr), 0);
  endtask

  // Scoreboard monitor: every write the DUT issues must match the oldest
  // expected write.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_wen: got bank=%0d adr=%0d, expected no write", wbank, wadr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (int'(wadr) != e.adr || int'(wbank) != e.bank) begin
          fails++;
          $display("[TB] FAIL write: got bank=%0d adr=%0d, expected bank=%0d adr=%0d",
                   wbank, wadr, e.bank, e.adr);
        end else begin
          $display("[TB] write bank=%0d adr=%0d", wbank, wadr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; config_en = 1'b0; config_data = '0; in_valid = 1'b0; rd_release = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    check("wadr_reset", int'(wadr), 0);
    check("wen_reset",  int'(wen),  0);

    // Fill bank 0, fill bank 1, stall, release, resume
    cfg(3, 2, 2, 1'b0);
    run(12, 100, 0);
    run(12, 100, 0);
    run(4, 100, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    run(6, 100, 0);

    // Alternating valid across a tile
    cfg(3, 2, 2, 1'b0);
    for (int i = 0; i < 26; i++) cycle(i % 2 == 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Release on the same cycle as the last write of bank 1
    cfg(3, 2, 2, 1'b0);
    run(12, 100, 0);
    run(11, 100, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    run(6, 100, 0);

    // Invalid configurations, then the largest legal tile
    cfg(3, 0, 2, 1'b1);
    run(5, 100, 50);
    cfg(16, 16, 2, 1'b1);
    run(5, 100, 50);
    cfg(16, 16, 1, 1'b0);
    run(256, 100, 0);
    run(300, 100, 30);

    // Reset mid-tile, then config mid-tile (offered word dropped)
    cfg(3, 2, 2, 1'b0);
    run(6, 100, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("wadr_after_rst", int'(wadr), 0);
    cfg(3, 2, 2, 1'b1);
    run(6, 100, 0);
    cfg(3, 2, 2, 1'b1);
    run(14, 100, 0);

    // Random shapes with random valid/release traffic
    for (int k = 0; k < 10; k++) begin
      cfg($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3), 1'b0);
      run(150, 70, 20);
    end

    run(2, 0, 0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifmap_wadr_gen.md
Name: ifmap_wadr_gen

Overview:
Write-side address generator and ping-pong controller for the input-activation double buffer. It accepts a valid/ready ifmap word stream from the DRAM-side loader. For each handshake it produces a bank-local write address and write enable. It also tracks which of the two banks holds a complete tile, so the read-side address generator consumes only full banks and releases them when done.

Parameters:
BANK_ADDR_WIDTH, 8, width of the bank-local write address and of each config field.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
config_en  input  1  load config_data; aborts any tile in progress.
config_data  input  3*BANK_ADDR_WIDTH  {IX0, IY0, IC1}, IX0 in MSBs.
in_valid  input  1  loader has an ifmap word this cycle.
in_ready  output  1  block accepts the word this cycle.
wen  output  1  write enable to the buffer, = in_valid & in_ready.
wadr  output  BANK_ADDR_WIDTH  bank-local write address, valid when wen=1.
wbank  output  1  bank being written.
tile_done  output  1  one-cycle pulse, cycle after a tile's last write.
rd_bank  output  1  bank the reader must consume next.
rd_bank_valid  output  1  rd_bank holds a complete tile.
rd_release  input  1  one-cycle pulse: reader finished rd_bank.
cfg_err  output  1  last config invalid (zero field or IX0*IY0*IC1 > 2^BANK_ADDR_WIDTH).

Behaviour:
- Reset (rst=1 at edge): config regs=0, configured=0, counters ix/iy/ic=0, lin=0, wbank=0, rd_bank=0, full[1:0]=0, tile_done=0, cfg_err=0. Outputs follow: in_ready=0, wen=0, wadr=0, rd_bank_valid=0. Reset wins over every other input in the same cycle.
- Config:
  - On config_en, latch fields and compute the tile size T=IX0*IY0*IC1 in 3*BANK_ADDR_WIDTH bits.
  - If any field is 0 or T > 2^BANK_ADDR_WIDTH: cfg_err=1, configured=0.
  - Otherwise: cfg_err=0, configured=1.
  - In both cases, clear counters, lin, wbank, rd_bank, full and tile_done.
  - config_en has priority over a handshake and over rd_release in the same cycle; that word is dropped.
- in_ready = configured & ~full[wbank], combinational from registers. It does not depend on in_valid.
- wen = in_valid & in_ready, combinational, zero latency. wadr = lin register.
- Write order: ix fastest, then iy, then ic, so lin = ic*IX0*IY0 + iy*IX0 + ix. The read generator assumes this layout.
- On each wen:
  - ix increments. It wraps to 0 at IX0-1, which carries into iy.
  - iy wraps at IY0-1, which carries into ic.
  - lin increments.
- Last write of the tile (ix=IX0-1, iy=IY0-1, ic=IC1-1 with wen):
  - Counters and lin return to 0.
  - full[wbank] is set and wbank toggles.
  - tile_done=1 next cycle.
- If the new wbank is still full, in_ready drops to 0 the next cycle and stays low until that bank is released.
- rd_bank_valid = full[rd_bank].
- On rd_release:
  - If full[rd_bank]=1: clear full[rd_bank] and toggle rd_bank.
  - If full[rd_bank]=0: ignore the pulse; no state change.
- Simultaneous last write and rd_release on different banks: both take effect in that cycle.
- Because release applies at the edge, in_ready to the freed bank rises in the cycle after rd_release.
- Counters wrap only at tile boundaries; lin never exceeds T-1.
- When configured=0, no state advances except config and reset.
- No FSM encoding is mandated. Externally visible states:
  - UNCFG (configured=0).
  - FILL (in_ready=1).
  - STALL (configured & full[wbank]).

Test Plan:
- Reset then config IX0=3, IY0=2, IC1=2, in_valid held 1 -> wadr 0..11 on consecutive cycles with wbank=0. tile_done pulses the cycle after wadr=11. wbank=1, rd_bank_valid=1, rd_bank=0.
- Continue streaming with no rd_release -> bank 1 fills with wadr 0..11. Then in_ready=0, full=2'b11, wen stays 0 despite in_valid=1. Pulse rd_release -> next cycle in_ready=1, wbank=0, rd_bank=1.
- Toggle in_valid 1,0,1,0 across a tile -> wadr advances only on wen cycles; no address skipped or repeated.
- Assert rd_release on the same cycle as the last write, with bank 0 full and bank 1 being written -> both banks' flags updated correctly, rd_bank=1, no stall.
- Config IY0=0, and separately IX0=16, IY0=16, IC1=2 with W=8 -> cfg_err=1, in_ready=0. Then IX0=16, IY0=16, IC1=1 -> cfg_err=0, wadr runs 0..255.
- Assert rst mid-tile (after wadr=5), and separately config_en mid-tile -> the next cycle shows all flags clear and wadr=0. The config_en cycle's word is not written.
